nn_deltabp_array: RTL and testbench

NN_DELTABP_ARRAY -- requirements
Module: NN_DELTABP_ARRAY

---
 rtl/nn_deltabp_array.sv | 112 +++++++++++
 tb/tb_nn_deltabp_array.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nn_deltabp_array.sv
// Stochastic back-propagation delta array: per channel, sums signed delta*weight
// bitstream terms into a saturating residue accumulator and emits a gated delta stream.
module nn_deltabp_array #(
    parameter int N     = 3,
    parameter int M     = 4,
    parameter int ACC_W = 6
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             EN,
    input  logic             CLR,
    input  logic [N-1:0]     delta,
    input  logic [N-1:0]     SIGN,
    input  logic [M*N-1:0]   alpha,
    input  logic [M*N-1:0]   WSIGN,
    input  logic [M-1:0]     DSIG,
    output logic [M-1:0]     delta_out,
    output logic [M-1:0]     SIGN_out,
    output logic [M-1:0]     SAT
);

    localparam int CW = $clog2(N + 1);
    // Wide enough to hold acc + D without wrap before clipping.
    localparam int AW = ACC_W + CW + 1;
    localparam logic signed [AW-1:0] LIM = AW'((1 << (ACC_W - 1)) - 1);

    for (genvar m = 0; m < M; m++) begin : g_ch
        logic [CW-1:0]             p_cnt;
        logic [CW-1:0]             q_cnt;
        logic signed [AW-1:0]      a_full;
        logic signed [AW-1:0]      a_sat;
        logic                      clip;
        logic                      e;
        logic                      s;
        logic signed [ACC_W-1:0]   acc;
        logic signed [ACC_W-1:0]   acc_nxt;
        logic                      d_q;
        logic                      s_q;
        logic                      sat_q;

        // NOTE: every variable gets a default before any branch so no latch is inferred.
        always_comb begin
            p_cnt   = '0;
            q_cnt   = '0;
            a_full  = '0;
            a_sat   = '0;
            clip    = 1'b0;
            e       = 1'b0;
            s       = 1'b0;
            acc_nxt = '0;

            for (int n = 0; n < N; n++) begin
                if (delta[n] & alpha[m*N+n]) begin
                    if (SIGN[n] ^ WSIGN[m*N+n])
                        q_cnt = q_cnt + CW'(1);
                    else
                        p_cnt = p_cnt + CW'(1);
                end
            end

            a_full = AW'(acc) + AW'({1'b0, p_cnt}) - AW'({1'b0, q_cnt});

            if (a_full > LIM) begin
                a_sat = LIM;
                clip  = 1'b1;
            end else if (a_full < -LIM) begin
                a_sat = -LIM;
                clip  = 1'b1;
            end else begin
                a_sat = a_full;
            end

            // Residue moves one step toward zero whenever a bit is emitted, independent of DSIG.
            if (a_sat > 0) begin
                e       = 1'b1;
                acc_nxt = ACC_W'(a_sat - AW'(1));
            end else if (a_sat < 0) begin
                e       = 1'b1;
                s       = 1'b1;
                acc_nxt = ACC_W'(a_sat + AW'(1));
            end
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge CLK or posedge INIT) begin
            if (INIT) begin
                acc   <= '0;
                d_q   <= 1'b0;
                s_q   <= 1'b0;
                sat_q <= 1'b0;
            end else if (CLR) begin
                acc   <= '0;
                d_q   <= 1'b0;
                s_q   <= 1'b0;
                sat_q <= 1'b0;
            end else if (EN) begin
                acc   <= acc_nxt;
                d_q   <= e & DSIG[m];
                s_q   <= s & e & DSIG[m];
                sat_q <= sat_q | clip;
            end else begin
                d_q   <= 1'b0;
                s_q   <= 1'b0;
            end
        end

        assign delta_out[m] = d_q;
        assign SIGN_out[m]  = s_q;
        assign SAT[m]       = sat_q;
    end

endmodule

// File: tb/tb_nn_deltabp_array.sv
// Directed self-checking bench for nn_deltabp_array with N=3, M=2, ACC_W=6.
module tb_nn_deltabp_array;

    localparam int N     = 3;
    localparam int M     = 2;
    localparam int ACC_W = 6;

    logic           CLK = 1'b0;
    logic           INIT;
    logic           EN;
    logic           CLR;
    logic [N-1:0]   delta;
    logic [N-1:0]   SIGN;
    logic [M*N-1:0] alpha;
    logic [M*N-1:0] WSIGN;
    logic [M-1:0]   DSIG;
    logic [M-1:0]   delta_out;
    logic [M-1:0]   SIGN_out;
    logic [M-1:0]   SAT;

    int n_tests = 0;
    int n_fail  = 0;

    nn_deltabp_array #(.N(N), .M(M), .ACC_W(ACC_W)) dut (
        .CLK       (CLK),
        .INIT      (INIT),
        .EN        (EN),
        .CLR       (CLR),
        .delta     (delta),
        .SIGN      (SIGN),
        .alpha     (alpha),
        .WSIGN     (WSIGN),
        .DSIG      (DSIG),
        .delta_out (delta_out),
        .SIGN_out  (SIGN_out),
        .SAT       (SAT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic zero_in();
        delta = '0;
        SIGN  = '0;
        alpha = '0;
        WSIGN = '0;
    endtask

    // Drive D=+3 on channel 0 only.
    task automatic plus3_ch0();
        delta = 3'b111;
        SIGN  = 3'b000;
        alpha = 6'b000_111;
        WSIGN = '0;
    endtask

    initial begin
        INIT = 1'b1;
        EN   = 1'b1;
        CLR  = 1'b0;
        DSIG = 2'b11;
        zero_in();
        #2;
        check("rst_dout", 32'(delta_out), 32'h0);
        check("rst_sign", 32'(SIGN_out), 32'h0);
        check("rst_sat",  32'(SAT), 32'h0);
        step();
        step();
        INIT = 1'b0;

        // Single positive term on channel 0.
        delta = 3'b001;
        alpha = 6'b000_001;
        for (int i = 0; i < 4; i++) begin
            step();
            check("single_dout", 32'(delta_out), 32'h1);
            check("single_sign", 32'(SIGN_out), 32'h0);
        end
        zero_in();
        step();
        check("single_acc0", 32'(delta_out), 32'h0);

        // D=+3 once, residue drains over two more cycles.
        plus3_ch0();
        step();
        check("p3_c0", 32'(delta_out), 32'h1);
        zero_in();
        step();
        check("p3_c1", 32'(delta_out), 32'h1);
        step();
        check("p3_c2", 32'(delta_out), 32'h1);
        check("p3_c2s", 32'(SIGN_out), 32'h0);
        step();
        check("p3_c3", 32'(delta_out), 32'h0);

        // D=-3 once: three negative output bits.
        plus3_ch0();
        SIGN = 3'b111;
        step();
        check("m3_c0", 32'(SIGN_out), 32'h1);
        zero_in();
        step();
        check("m3_c1", 32'(SIGN_out), 32'h1);
        step();
        check("m3_c2d", 32'(delta_out), 32'h1);
        check("m3_c2s", 32'(SIGN_out), 32'h1);
        step();
        check("m3_c3d", 32'(delta_out), 32'h0);
        check("m3_c3s", 32'(SIGN_out), 32'h0);

        // Cancellation: n0 positive, n1 negative.
        delta = 3'b011;
        SIGN  = 3'b010;
        alpha = 6'b000_011;
        step();
        check("cancel_d", 32'(delta_out), 32'h0);
        zero_in();
        step();
        check("cancel_acc", 32'(delta_out), 32'h0);

        // Channel 1 alone, negative via weight sign.
        delta = 3'b100;
        alpha = 6'b100_000;
        WSIGN = 6'b100_000;
        step();
        check("ch1_d", 32'(delta_out), 32'h2);
        check("ch1_s", 32'(SIGN_out), 32'h2);
        zero_in();
        step();
        check("ch1_drain", 32'(delta_out), 32'h0);

        // Saturation: acc reaches 30 after 15 cycles; cycle 16 clips A=33 to 31.
        plus3_ch0();
        for (int i = 1; i <= 20; i++) begin
            step();
            check("sat_dout", 32'(delta_out), 32'h1);
            if (i == 15) check("sat_pre", 32'(SAT), 32'h0);
            if (i == 16) check("sat_set", 32'(SAT), 32'h1);
        end
        zero_in();
        for (int i = 0; i < 5; i++) step();
        check("sat_sticky", 32'(SAT), 32'h1);
        check("sat_drain", 32'(delta_out), 32'h1);
        CLR = 1'b1;
        step();
        check("clr_d", 32'(delta_out), 32'h0);
        check("clr_sat", 32'(SAT), 32'h0);
        CLR = 1'b0;
        step();
        check("clr_acc", 32'(delta_out), 32'h0);

        // CLR has priority over EN.
        plus3_ch0();
        CLR = 1'b1;
        step();
        check("clr_pri", 32'(delta_out), 32'h0);
        CLR = 1'b0;
        zero_in();
        step();
        check("clr_pri_acc", 32'(delta_out), 32'h0);

        // EN low holds acc=2 while outputs read 0.
        plus3_ch0();
        step();
        EN = 1'b0;
        step();
        check("en_hold0", 32'(delta_out), 32'h0);
        step();
        check("en_hold1", 32'(delta_out), 32'h0);
        EN = 1'b1;
        zero_in();
        step();
        check("en_res0", 32'(delta_out), 32'h1);
        step();
        check("en_res1", 32'(delta_out), 32'h1);
        step();
        check("en_res2", 32'(delta_out), 32'h0);

        // Derivative gating: residue still decremented.
        delta = 3'b001;
        alpha = 6'b000_001;
        DSIG  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("gate_d", 32'(delta_out), 32'h0);
            check("gate_s", 32'(SIGN_out), 32'h0);
        end
        DSIG = 2'b11;
        zero_in();
        step();
        check("gate_acc", 32'(delta_out), 32'h0);

        // Build acc0=10, then asynchronous INIT between edges.
        plus3_ch0();
        for (int i = 0; i < 5; i++) step();
        check("ar_pre", 32'(delta_out), 32'h1);
        #2;
        INIT = 1'b1;
        #1;
        check("ar_async_d", 32'(delta_out), 32'h0);
        check("ar_async_sat", 32'(SAT), 32'h0);
        #1;
        INIT = 1'b0;
        zero_in();
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_after", 32'(delta_out), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
